// File: rtl/reg_write_arbiter_if.sv
// Register-write bus between three requesters, the arbiter and the register bank.
// Requesters and register bank use the master view; the arbiter uses the slave view.
interface reg_write_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = 2
);
  logic [2:0]       req;
  logic [AW-1:0]    addr0;
  logic [AW-1:0]    addr1;
  logic [AW-1:0]    addr2;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [2:0]       ack;
  logic [NREGS-1:0] en;
  logic [WIDTH-1:0] wdata;
  logic             busy;

  modport master (
    output req, addr0, addr1, addr2, data0, data1, data2,
    input  ack, en, wdata, busy
  );

  modport slave (
    input  req, addr0, addr1, addr2, data0, data1, data2,
    output ack, en, wdata, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter giving three requesters single-cycle write access to a register bank.
// state | meaning
// ARB   | idle or choosing the next requester; outputs quiet
// WRITE | one cycle: en/ack/wdata/busy present the latched write
module reg_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input logic                clk,
  input logic                nreset,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic {
    ARB   = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [1:0]       last_grant;
  logic [1:0]       lat_idx;
  logic [WIDTH-1:0] lat_data;
  logic [NREGS-1:0] en_q;
  logic [2:0]       ack_q;

  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic [NREGS-1:0] en_d;
  logic [2:0]       ack_d;

  // Search starts one past the last winner and wraps, so each requester waits at most two grants.
  always_comb begin
    int cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    for (int off = 1; off <= 3; off++) begin
      cand = (int'(last_grant) + off) % 3;
      if (!grant_valid && bus.req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(cand);
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd1:    begin sel_addr = bus.addr1; sel_data = bus.data1; end
      2'd2:    begin sel_addr = bus.addr2; sel_data = bus.data2; end
      default: begin sel_addr = bus.addr0; sel_data = bus.data0; end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ARB;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ARB:     if (grant_valid) state_d = WRITE;
      WRITE:   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Out-of-range addresses decode to no enable bit, so the write is dropped but still acked.
  always_comb begin
    en_d  = '0;
    ack_d = '0;
    if (state == ARB && grant_valid) begin
      ack_d = 3'b001 << grant_idx;
      for (int k = 0; k < NREGS; k++) begin
        if (sel_addr == AW'(k)) en_d[k] = 1'b1;
      end
    end
  end

  // en_q holds the latched address in decoded form; lat_data doubles as the held wdata bus.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_grant <= 2'd2;
      lat_idx    <= 2'd0;
      lat_data   <= '0;
      en_q       <= '0;
      ack_q      <= '0;
    end else begin
      en_q  <= en_d;
      ack_q <= ack_d;
      if (state == ARB && grant_valid) begin
        lat_idx  <= grant_idx;
        lat_data <= sel_data;
      end
      if (state == WRITE) last_grant <= lat_idx;
    end
  end

  assign bus.en    = en_q;
  assign bus.ack   = ack_q;
  assign bus.wdata = lat_data;
  assign bus.busy  = (state == WRITE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model of round-robin arbitration and the register bank contents.
module tb_reg_write_arbiter;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.WIDTH(8), .NREGS(4), .AW(2)) bus4 ();
  reg_write_arbiter_if #(.WIDTH(8), .NREGS(3), .AW(2)) bus3 ();

  reg_write_arbiter #(.WIDTH(8), .NREGS(4), .AW(2)) dut4 (.clk(clk), .nreset(nreset), .bus(bus4));
  reg_write_arbiter #(.WIDTH(8), .NREGS(3), .AW(2)) dut3 (.clk(clk), .nreset(nreset), .bus(bus3));

  int errors = 0;
  int checks = 0;

  // Register bank fed by the arbiter.
  logic [7:0] regs4 [4];
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < 4; k++) regs4[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) if (bus4.en[k]) regs4[k] <= bus4.wdata;
    end
  end

  // Transaction-level reference: who wins, what appears on the bus, what the bank holds.
  int         m_last;
  int         m_grant;
  bit         m_occupied;
  logic [3:0] exp_en;
  logic [2:0] exp_ack;
  logic       exp_busy;
  logic [7:0] exp_wdata;
  logic [7:0] mreg [4];

  function automatic logic [1:0] req_addr(int c);
    case (c)
      0:       return bus4.addr0;
      1:       return bus4.addr1;
      default: return bus4.addr2;
    endcase
  endfunction

  function automatic logic [7:0] req_data(int c);
    case (c)
      0:       return bus4.data0;
      1:       return bus4.data1;
      default: return bus4.data2;
    endcase
  endfunction

  function automatic void model_reset();
    m_last = 2; m_grant = -1; m_occupied = 1'b0;
    exp_en = '0; exp_ack = '0; exp_busy = 1'b0; exp_wdata = '0;
    for (int k = 0; k < 4; k++) mreg[k] = '0;
  endfunction

  // Predicts what the outputs show after the coming clock edge, given current requests.
  function automatic void model_step();
    int a;
    m_grant = -1;
    exp_en = '0; exp_ack = '0; exp_busy = 1'b0;
    if (m_occupied) begin
      m_occupied = 1'b0;
    end else if (bus4.req != 3'b000) begin
      for (int n = 1; n <= 3; n++) begin
        if (m_grant < 0 && bus4.req[(m_last + n) % 3]) m_grant = (m_last + n) % 3;
      end
      m_last     = m_grant;
      a          = int'(req_addr(m_grant));
      exp_ack    = 3'(1 << m_grant);
      exp_en     = (a < 4) ? 4'(1 << a) : 4'b0000;
      exp_wdata  = req_data(m_grant);
      exp_busy   = 1'b1;
      m_occupied = 1'b1;
      if (a < 4) mreg[a] = exp_wdata;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus4.req = '0; bus4.addr0 = '0; bus4.addr1 = '0; bus4.addr2 = '0;
    bus4.data0 = '0; bus4.data1 = '0; bus4.data2 = '0;
    bus3.req = '0; bus3.addr0 = '0; bus3.addr1 = '0; bus3.addr2 = '0;
    bus3.data0 = '0; bus3.data1 = '0; bus3.data2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    clear_inputs();
    #2;
    nreset = 1'b1;
    model_reset();
  endtask

  task automatic set_req(int i, logic [1:0] a, logic [7:0] d);
    case (i)
      0:       begin bus4.addr0 = a; bus4.data0 = d; end
      1:       begin bus4.addr1 = a; bus4.data1 = d; end
      default: begin bus4.addr2 = a; bus4.data2 = d; end
    endcase
    bus4.req[i] = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus4.en !== 4'b0000) begin errors++; $display("FAIL reset_en got=%b want=0000", bus4.en); end
    checks++; if (bus4.ack !== 3'b000) begin errors++; $display("FAIL reset_ack got=%b want=000", bus4.ack); end
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus4.busy); end
    checks++; if (bus4.wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%h want=00", bus4.wdata); end
    nreset = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 2'd2, 8'hA5);
    tick();
    checks++; if (bus4.en !== 4'b0100) begin errors++; $display("FAIL single_en got=%b want=0100", bus4.en); end
    checks++; if (bus4.wdata !== 8'hA5) begin errors++; $display("FAIL single_wdata got=%h want=a5", bus4.wdata); end
    checks++; if (bus4.ack !== 3'b001) begin errors++; $display("FAIL single_ack got=%b want=001", bus4.ack); end
    checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=1", bus4.busy); end
    bus4.req = '0;
    tick();
    checks++; if (bus4.en !== 4'b0000) begin errors++; $display("FAIL single_en_after got=%b want=0000", bus4.en); end
    checks++; if (bus4.ack !== 3'b000) begin errors++; $display("FAIL single_ack_after got=%b want=000", bus4.ack); end
    tick();
    checks++; if (regs4[2] !== 8'hA5) begin errors++; $display("FAIL single_reg2 got=%h want=a5", regs4[2]); end
  endtask

  task automatic test_rotation();
    logic [2:0] seen [$];
    logic [2:0] want [6];
    want = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 2'($urandom_range(0, 3)), 8'(8'h10 * (i + 1)));
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if (bus4.en !== exp_en) begin errors++; $display("FAIL rot_en c%0d got=%b want=%b", c, bus4.en, exp_en); end
      checks++; if (bus4.ack !== exp_ack) begin errors++; $display("FAIL rot_ack c%0d got=%b want=%b", c, bus4.ack, exp_ack); end
      checks++; if (bus4.wdata !== exp_wdata) begin errors++; $display("FAIL rot_wdata c%0d got=%h want=%h", c, bus4.wdata, exp_wdata); end
      checks++; if (!$onehot0(bus4.en)) begin errors++; $display("FAIL rot_en_onehot c%0d got=%b want=onehot0", c, bus4.en); end
      if (bus4.ack != 3'b000) begin
        seen.push_back(bus4.ack);
        for (int i = 0; i < 3; i++)
          if (bus4.ack[i]) set_req(i, 2'($urandom_range(0, 3)), 8'($urandom));
      end
    end
    checks++; if (seen.size() != 6) begin errors++; $display("FAIL rot_count got=%0d want=6", seen.size()); end
    for (int k = 0; k < 6 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== want[k]) begin errors++; $display("FAIL rot_seq%0d got=%b want=%b", k, seen[k], want[k]); end
    end
    bus4.req = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (regs4[k] !== mreg[k]) begin errors++; $display("FAIL rot_reg%0d got=%h want=%h", k, regs4[k], mreg[k]); end
    end
  endtask

  task automatic test_same_reg();
    do_reset();
    set_req(1, 2'd0, 8'h5C);
    tick();
    checks++; if (bus4.ack !== 3'b010) begin errors++; $display("FAIL same_first_ack got=%b want=010", bus4.ack); end
    bus4.req = '0;
    tick();
    set_req(1, 2'd1, 8'h11);
    set_req(2, 2'd1, 8'h22);
    tick();
    checks++; if (bus4.ack !== 3'b100) begin errors++; $display("FAIL same_ack2 got=%b want=100", bus4.ack); end
    checks++; if (bus4.wdata !== 8'h22) begin errors++; $display("FAIL same_wdata2 got=%h want=22", bus4.wdata); end
    bus4.req[2] = 1'b0;
    tick();
    checks++; if (bus4.ack !== 3'b000) begin errors++; $display("FAIL same_gap_ack got=%b want=000", bus4.ack); end
    tick();
    checks++; if (bus4.ack !== 3'b010) begin errors++; $display("FAIL same_ack1 got=%b want=010", bus4.ack); end
    checks++; if (bus4.en !== 4'b0010) begin errors++; $display("FAIL same_en1 got=%b want=0010", bus4.en); end
    bus4.req = '0;
    tick();
    tick();
    checks++; if (regs4[1] !== 8'h11) begin errors++; $display("FAIL same_reg1 got=%h want=11", regs4[1]); end
    checks++; if (regs4[0] !== mreg[0]) begin errors++; $display("FAIL same_reg0 got=%h want=%h", regs4[0], mreg[0]); end
  endtask

  task automatic test_bad_addr();
    do_reset();
    bus3.req = 3'b001; bus3.addr0 = 2'd3; bus3.data0 = 8'h5A;
    tick();
    checks++; if (bus3.ack !== 3'b001) begin errors++; $display("FAIL bad_ack got=%b want=001", bus3.ack); end
    checks++; if (bus3.en !== 3'b000) begin errors++; $display("FAIL bad_en got=%b want=000", bus3.en); end
    bus3.req = '0;
    tick();
    checks++; if (bus3.en !== 3'b000) begin errors++; $display("FAIL bad_en_after got=%b want=000", bus3.en); end
    checks++; if (bus3.ack !== 3'b000) begin errors++; $display("FAIL bad_ack_after got=%b want=000", bus3.ack); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    set_req(0, 2'd1, 8'hC3);
    tick();
    checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_pre got=%b want=1", bus4.busy); end
    #2;
    nreset = 1'b0;
    #1;
    checks++; if (bus4.en !== 4'b0000) begin errors++; $display("FAIL midrst_en got=%b want=0000", bus4.en); end
    checks++; if (bus4.ack !== 3'b000) begin errors++; $display("FAIL midrst_ack got=%b want=000", bus4.ack); end
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", bus4.busy); end
    checks++; if (bus4.wdata !== 8'h00) begin errors++; $display("FAIL midrst_wdata got=%h want=00", bus4.wdata); end
    bus4.req = '0;
    @(negedge clk);
    nreset = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus4.en !== 4'b0000 || bus4.ack !== 3'b000) begin
        errors++; $display("FAIL midrst_idle c%0d got=%b/%b want=0000/000", c, bus4.en, bus4.ack);
      end
    end
    checks++; if (regs4[1] !== 8'h00) begin errors++; $display("FAIL midrst_reg1 got=%h want=00", regs4[1]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 2'd3, 8'h77);
    tick();
    checks++; if (bus4.ack !== 3'b001) begin errors++; $display("FAIL b2b_ack1 got=%b want=001", bus4.ack); end
    tick();
    checks++; if (bus4.ack !== 3'b000) begin errors++; $display("FAIL b2b_gap_ack got=%b want=000", bus4.ack); end
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy got=%b want=0", bus4.busy); end
    tick();
    checks++; if (bus4.ack !== 3'b001) begin errors++; $display("FAIL b2b_ack2 got=%b want=001", bus4.ack); end
    checks++; if (bus4.en !== 4'b1000) begin errors++; $display("FAIL b2b_en2 got=%b want=1000", bus4.en); end
    bus4.req = '0;
    tick();
    checks++; if (bus4.ack !== 3'b000) begin errors++; $display("FAIL b2b_ack_end got=%b want=000", bus4.ack); end
  endtask

  task automatic test_random();
    int waits [3];
    do_reset();
    for (int i = 0; i < 3; i++) waits[i] = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      checks++; if (bus4.en !== exp_en) begin errors++; $display("FAIL rnd_en c%0d got=%b want=%b", c, bus4.en, exp_en); end
      checks++; if (bus4.ack !== exp_ack) begin errors++; $display("FAIL rnd_ack c%0d got=%b want=%b", c, bus4.ack, exp_ack); end
      checks++; if (bus4.busy !== exp_busy) begin errors++; $display("FAIL rnd_busy c%0d got=%b want=%b", c, bus4.busy, exp_busy); end
      checks++; if (bus4.wdata !== exp_wdata) begin errors++; $display("FAIL rnd_wdata c%0d got=%h want=%h", c, bus4.wdata, exp_wdata); end
      if (bus4.ack != 3'b000) begin
        for (int i = 0; i < 3; i++) begin
          if (bus4.ack[i]) waits[i] = 0;
          else if (bus4.req[i]) begin
            waits[i]++;
            checks++; if (waits[i] > 2) begin errors++; $display("FAIL rnd_starve req%0d got=%0d want<=2", i, waits[i]); end
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (bus4.ack[i]) begin
          if ($urandom_range(0, 1) == 1) set_req(i, 2'($urandom_range(0, 3)), 8'($urandom));
          else bus4.req[i] = 1'b0;
        end else if (!bus4.req[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 2'($urandom_range(0, 3)), 8'($urandom));
        end
      end
    end
    bus4.req = '0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (regs4[k] !== mreg[k]) begin errors++; $display("FAIL rnd_reg%0d got=%h want=%h", k, regs4[k], mreg[k]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_same_reg();
    test_bad_addr();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
